cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Cache controller FSM: same-cycle hits, dirty-victim write-back and line refill,
// one word per accepted memory beat.
`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_S
`define CACHE_S 2
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_controller #(
    parameter int unsigned TAG_WIDTH    = `CACHE_T,
    parameter int unsigned SET_WIDTH    = `CACHE_S,
    parameter int unsigned OFFSET_WIDTH = `CACHE_B
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 mem_ready_i,
    output logic                 ready_o,
    output logic [4:0]           control_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_read_en_o,
    output logic                 mem_write_en_o
);

    localparam int unsigned CntWidth = OFFSET_WIDTH - 2;
    localparam logic [CntWidth-1:0] CntLast = {CntWidth{1'b1}};

    typedef enum logic [1:0] {StIdle, StWriteBack, StAllocate} state_e;

    state_e                 state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic                   mem_read_en_q;
    logic                   mem_write_en_q;

    logic                   req;
    logic [SET_WIDTH-1:0]   index;
    logic [TAG_WIDTH-1:0]   addr_tag;
    logic                   unused_offset;

    assign req           = read_i | write_i;
    assign index         = addr_i[OFFSET_WIDTH +: SET_WIDTH];
    assign addr_tag      = addr_i[31 -: TAG_WIDTH];
    assign unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

    assign mem_read_en_o  = mem_read_en_q;
    assign mem_write_en_o = mem_write_en_q;

    // Memory enables are registered alongside the state so they follow it exactly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req && !hit_i) begin
                        cnt_q <= '0;
                        if (dirty_i) begin
                            state_q        <= StWriteBack;
                            mem_write_en_q <= 1'b1;
                        end else begin
                            state_q       <= StAllocate;
                            mem_read_en_q <= 1'b1;
                        end
                    end
                end
                StWriteBack: begin
                    if (mem_ready_i) begin
                        if (cnt_q == CntLast) begin
                            cnt_q          <= '0;
                            state_q        <= StAllocate;
                            mem_write_en_q <= 1'b0;
                            mem_read_en_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntWidth'(1);
                        end
                    end
                end
                StAllocate: begin
                    if (mem_ready_i) begin
                        if (cnt_q == CntLast) begin
                            cnt_q         <= '0;
                            state_q       <= StIdle;
                            mem_read_en_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CntWidth'(1);
                        end
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    cnt_q          <= '0;
                    mem_read_en_q  <= 1'b0;
                    mem_write_en_q <= 1'b0;
                end
            endcase
        end
    end

    // control_o = {write_en, set_valid, set_dirty, strategy_en, offset_sel}
    always_comb begin
        ready_o    = 1'b0;
        control_o  = 5'b00000;
        mem_addr_o = 32'h0;
        case (state_q)
            StIdle: begin
                if (!req) begin
                    control_o = 5'b00001;
                end else if (hit_i) begin
                    ready_o   = !rst_i;
                    control_o = write_i ? 5'b11111 : 5'b00011;
                end
            end
            StWriteBack: begin
                mem_addr_o = {tag_i, index, cnt_q, 2'b00};
            end
            StAllocate: begin
                mem_addr_o = {addr_tag, index, cnt_q, 2'b00};
                if (mem_ready_i) begin
                    control_o = 5'b11000;
                end
            end
            default: ;
        endcase
    end

endmodule
